// File: rtl/morse_emitter.sv
// Morse keyer: turns one ASCII character at a time into timed mark/space on morse_o.
// Latency: morse_o rises in the first cycle after the acceptance edge; all durations are exact multiples of the dot period.
// Backpressure: char_ready_o is high only while idle, so a character is taken only between emissions.

package morse_pkg;

  // size = number of symbols, value[0] is sent first, 1 = dash, 0 = dot
  typedef struct packed {
    logic [2:0] size;
    logic [4:0] value;
  } morse_code_t;

  localparam morse_code_t letter_conversion_c [26] = '{
    '{3'd2, 5'd2},   // A .-
    '{3'd4, 5'd1},   // B -...
    '{3'd4, 5'd5},   // C -.-.
    '{3'd3, 5'd1},   // D -..
    '{3'd1, 5'd0},   // E .
    '{3'd4, 5'd4},   // F ..-.
    '{3'd3, 5'd3},   // G --.
    '{3'd4, 5'd0},   // H ....
    '{3'd2, 5'd0},   // I ..
    '{3'd4, 5'd14},  // J .---
    '{3'd3, 5'd5},   // K -.-
    '{3'd4, 5'd2},   // L .-..
    '{3'd2, 5'd3},   // M --
    '{3'd2, 5'd1},   // N -.
    '{3'd3, 5'd7},   // O ---
    '{3'd4, 5'd6},   // P .--.
    '{3'd4, 5'd11},  // Q --.-
    '{3'd3, 5'd2},   // R .-.
    '{3'd3, 5'd0},   // S ...
    '{3'd1, 5'd1},   // T -
    '{3'd3, 5'd4},   // U ..-
    '{3'd4, 5'd8},   // V ...-
    '{3'd3, 5'd6},   // W .--
    '{3'd4, 5'd9},   // X -..-
    '{3'd4, 5'd13},  // Y -.--
    '{3'd4, 5'd3}    // Z --..
  };

  localparam morse_code_t number_conversion_c [10] = '{
    '{3'd5, 5'd31},  // 0 -----
    '{3'd5, 5'd30},  // 1 .----
    '{3'd5, 5'd28},  // 2 ..---
    '{3'd5, 5'd24},  // 3 ...--
    '{3'd5, 5'd16},  // 4 ....-
    '{3'd5, 5'd0},   // 5 .....
    '{3'd5, 5'd1},   // 6 -....
    '{3'd5, 5'd3},   // 7 --...
    '{3'd5, 5'd7},   // 8 ---..
    '{3'd5, 5'd15}   // 9 ----.
  };

endpackage

module morse_emitter
  import morse_pkg::*;
#(
  parameter int DOT_PERIOD_WIDTH = 28
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [DOT_PERIOD_WIDTH-1:0] dot_period_i,
  input  logic [7:0]                  char_i,
  input  logic                        char_valid_i,
  output logic                        char_ready_o,
  output logic                        morse_o,
  output logic                        busy_o,
  output logic                        unknown_o
);

  localparam int DW = DOT_PERIOD_WIDTH;
  // two extra bits so that 4 x the largest dot period still fits
  localparam int CW = DOT_PERIOD_WIDTH + 2;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    SYM_GAP,
    CHAR_GAP,
    WORD_GAP
  } state_t;

  typedef enum logic [1:0] {
    K_OTHER,
    K_SYM,
    K_SPACE
  } kind_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;     // cycles left in the current state, minus one
  logic [DW-1:0] dot_q, dot_d;     // latched dot period, never zero
  logic [4:0]  code_q, code_d;     // symbols still to send, next one in bit 0
  logic [2:0]  left_q, left_d;     // symbols still to send after the current mark
  logic        unk_d;

  logic        morse_q, busy_q, ready_q, unk_q;

  kind_t       kind;
  morse_code_t lut;
  logic [4:0]  letter_idx;
  logic [3:0]  digit_idx;
  logic [DW-1:0] dp_eff;
  logic [CW-1:0] acc_x1, acc_x3, acc_x4;
  logic [CW-1:0] q_x1, q_x3;
  logic        accept;

  // classify the offered character and fetch its code
  always_comb begin
    kind       = K_OTHER;
    lut        = '0;
    letter_idx = '0;
    digit_idx  = '0;
    if (char_i >= 8'd65 && char_i <= 8'd90) begin
      letter_idx = 5'(char_i - 8'd65);
      lut        = letter_conversion_c[letter_idx];
      kind       = K_SYM;
    end else if (char_i >= 8'd97 && char_i <= 8'd122) begin
      letter_idx = 5'(char_i - 8'd97);
      lut        = letter_conversion_c[letter_idx];
      kind       = K_SYM;
    end else if (char_i >= 8'd48 && char_i <= 8'd57) begin
      digit_idx  = 4'(char_i - 8'd48);
      lut        = number_conversion_c[digit_idx];
      kind       = K_SYM;
    end else if (char_i == 8'd32) begin
      kind       = K_SPACE;
    end
  end

  // duration multiples: from the live input at acceptance, from the latched period afterwards
  always_comb begin
    dp_eff = (dot_period_i == '0) ? DW'(1) : dot_period_i;
    acc_x1 = {2'b00, dp_eff};
    acc_x3 = acc_x1 + {acc_x1[CW-2:0], 1'b0};
    acc_x4 = {dp_eff, 2'b00};
    q_x1   = {2'b00, dot_q};
    q_x3   = q_x1 + {q_x1[CW-2:0], 1'b0};
  end

  assign accept = char_valid_i && ready_q;

  // next-state logic: each timed state loads its length on entry and counts down to zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dot_d   = dot_q;
    code_d  = code_q;
    left_d  = left_q;
    unk_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          dot_d = dp_eff;
          unique case (kind)
            K_SYM: begin
              state_d = MARK;
              cnt_d   = (lut.value[0] ? acc_x3 : acc_x1) - CW'(1);
              code_d  = lut.value >> 1;
              left_d  = lut.size - 3'd1;
            end
            K_SPACE: begin
              state_d = WORD_GAP;
              cnt_d   = acc_x4 - CW'(1);
            end
            default: begin
              // unencodable: drop it, pulse unknown, stay ready
              unk_d = 1'b1;
            end
          endcase
        end
      end
      MARK: begin
        if (cnt_q == '0) begin
          if (left_q != 3'd0) begin
            state_d = SYM_GAP;
            cnt_d   = q_x1 - CW'(1);
          end else begin
            state_d = CHAR_GAP;
            cnt_d   = q_x3 - CW'(1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SYM_GAP: begin
        if (cnt_q == '0) begin
          state_d = MARK;
          cnt_d   = (code_q[0] ? q_x3 : q_x1) - CW'(1);
          code_d  = code_q >> 1;
          left_d  = left_q - 3'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      CHAR_GAP, WORD_GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dot_q   <= DW'(1);
      code_q  <= '0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dot_q   <= dot_d;
      code_q  <= code_d;
      left_q  <= left_d;
    end
  end

  // registered outputs decoded from the next state; ready stays low until the first edge after reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      morse_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      unk_q   <= 1'b0;
    end else begin
      morse_q <= (state_d == MARK);
      busy_q  <= (state_d != IDLE);
      ready_q <= (state_d == IDLE);
      unk_q   <= unk_d;
    end
  end

  assign morse_o      = morse_q;
  assign busy_o       = busy_q;
  assign char_ready_o = ready_q;
  assign unknown_o    = unk_q;

endmodule

// File: tb/tb_morse_emitter.sv
// Bench for morse_emitter: random characters against a dot/dash string model, plus pinned timings.
// Latency: the model predicts every output cycle-by-cycle from each acceptance edge.
// Backpressure: stimulus offers characters only when the model says the block is ready.
module tb_morse_emitter;

  localparam int DW = 28;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] dot_period = DW'(1);
  logic [7:0]    char_in = 8'd0;
  logic          char_valid = 1'b0;
  logic          char_ready, morse, busy, unknown;

  morse_emitter #(.DOT_PERIOD_WIDTH(DW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .dot_period_i(dot_period),
    .char_i      (char_in),
    .char_valid_i(char_valid),
    .char_ready_o(char_ready),
    .morse_o     (morse),
    .busy_o      (busy),
    .unknown_o   (unknown)
  );

  always #5 clk = ~clk;

  // expected outputs for one cycle: morse, busy, ready, unknown
  typedef struct packed {
    bit m;
    bit b;
    bit r;
    bit u;
  } exp_t;

  localparam exp_t E_MARK = 4'b1100;
  localparam exp_t E_GAP  = 4'b0100;
  localparam exp_t E_UNK  = 4'b0011;
  localparam exp_t E_IDLE = 4'b0010;
  localparam exp_t E_RST  = 4'b0000;

  exp_t  exp_q[$];
  exp_t  cur = E_RST;
  int    vectors = 0;
  int    miscompares = 0;
  bit    rst_fresh = 1'b1;

  // international Morse, A..Z then 0..9
  string tbl [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."
  };

  function automatic string pattern(logic [7:0] c);
    int v;
    v = int'(c);
    if (v >= 65 && v <= 90)  return tbl[v - 65];
    if (v >= 97 && v <= 122) return tbl[v - 97];
    if (v >= 48 && v <= 57)  return tbl[26 + v - 48];
    return "";
  endfunction

  task automatic check(string name, int act, int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    end
  endtask

  // append the expected cycles that follow acceptance of character c
  task automatic push_char(logic [7:0] c, logic [DW-1:0] dp);
    int    d;
    string p;
    d = (dp == '0) ? 1 : int'(dp);
    p = pattern(c);
    if (c == 8'd32) begin
      repeat (4 * d) exp_q.push_back(E_GAP);
    end else if (p.len() == 0) begin
      exp_q.push_back(E_UNK);
    end else begin
      for (int i = 0; i < p.len(); i++) begin
        repeat ((p[i] == 8'd45) ? 3 * d : d) exp_q.push_back(E_MARK);
        if (i < p.len() - 1) repeat (d) exp_q.push_back(E_GAP);
      end
      repeat (3 * d) exp_q.push_back(E_GAP);
    end
  endtask

  // compare process: check every cycle at the falling edge, register acceptances at the rising edge
  always begin
    @(negedge clk);
    if (rst || rst_fresh)        cur = E_RST;
    else if (exp_q.size() > 0)   cur = exp_q.pop_front();
    else                         cur = E_IDLE;
    check("morse_o",      int'(morse),      int'(cur.m));
    check("busy_o",       int'(busy),       int'(cur.b));
    check("char_ready_o", int'(char_ready), int'(cur.r));
    check("unknown_o",    int'(unknown),    int'(cur.u));
    @(posedge clk);
    if (!rst && !rst_fresh && cur.r && char_valid) push_char(char_in, dot_period);
    if (!rst) rst_fresh = 1'b0;
  end

  task automatic idle_cycles(int n);
    repeat (n) begin
      @(negedge clk); #2;
      char_valid = 1'b0;
      char_in    = 8'($urandom);
      dot_period = DW'($urandom);
    end
  endtask

  // offer c until accepted; junk is driven while the block is busy
  task automatic apply_char(logic [7:0] c, int dp, int idle_pct);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk); #2;
      if (cur.r && $urandom_range(99) >= idle_pct) begin
        char_valid = 1'b1;
        char_in    = c;
        dot_period = DW'(dp);
        @(posedge clk);
        done = 1'b1;
      end else begin
        char_valid = cur.r ? 1'b0 : 1'($urandom_range(1));
        char_in    = 8'($urandom);
        dot_period = DW'($urandom_range(20));
      end
    end
    if (!done) check("accept_timeout", 0, 1);
  endtask

  // pinned timing: cycles from acceptance until ready, number of mark cycles, first mark cycle
  task automatic time_char(logic [7:0] c, int dp, int exp_n, int exp_high);
    int n, highs, first;
    n = 0; highs = 0; first = 0;
    apply_char(c, dp, 0);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #2;
      char_valid = 1'b0;
      n++;
      if (morse) begin
        highs++;
        if (first == 0) first = n;
      end
      if (char_ready) break;
    end
    check("ready_latency", n, exp_n);
    check("mark_cycles", highs, exp_high);
    check("first_mark_cycle", first, 1);
  endtask

  string stream;
  string unk_set = "@[`{/:#!~";

  initial begin
    #1;
    check("reset_ready", int'(char_ready), 0);
    check("reset_morse", int'(morse), 0);
    check("reset_busy",  int'(busy), 0);
    idle_cycles(3);
    rst = 1'b0;

    // pinned single-character timings
    time_char(8'd69, 4, 17, 4);    // 'E'
    time_char(8'd65, 4, 33, 16);   // 'A'
    time_char(8'd97, 4, 33, 16);   // 'a'
    time_char(8'd48, 0, 23, 15);   // '0' with dot period 0

    // "E E" streamed with valid held
    stream = "E E";
    for (int i = 0; i < stream.len(); i++) apply_char(stream[i], 2, 0);
    idle_cycles(20);

    // unknown character, next one taken in the following cycle
    apply_char(8'd35, 3, 0);
    @(negedge clk); #1;
    check("unknown_pulse",   int'(unknown), 1);
    check("unknown_ready",   int'(char_ready), 1);
    check("unknown_no_mark", int'(morse), 0);
    #1;
    char_valid = 1'b1;
    char_in    = 8'd84;            // 'T'
    dot_period = DW'(2);
    @(posedge clk);
    @(negedge clk); #1;
    check("after_unknown_mark", int'(morse), 1);
    check("unknown_cleared",    int'(unknown), 0);
    idle_cycles(20);

    // asynchronous reset in the middle of a dash
    apply_char(8'd84, 8, 0);
    idle_cycles(6);
    check("pre_reset_mark", int'(morse), 1);
    rst = 1'b1;
    exp_q.delete();
    rst_fresh = 1'b1;
    #1;
    check("async_reset_morse", int'(morse), 0);
    check("async_reset_busy",  int'(busy), 0);
    check("async_reset_ready", int'(char_ready), 0);
    idle_cycles(2);
    rst = 1'b0;
    @(negedge clk); #1;
    check("ready_after_reset", int'(char_ready), 1);
    time_char(8'd69, 4, 17, 4);

    // random stream
    for (int k = 0; k < 120; k++) begin
      int   sel;
      logic [7:0] c;
      sel = $urandom_range(9);
      if (sel <= 3)      c = 8'(65 + $urandom_range(25));
      else if (sel <= 5) c = 8'(97 + $urandom_range(25));
      else if (sel <= 7) c = 8'(48 + $urandom_range(9));
      else if (sel == 8) c = 8'd32;
      else               c = unk_set[$urandom_range(unk_set.len() - 1)];
      apply_char(c, $urandom_range(3), (k % 3 == 0) ? 0 : 40);
    end
    idle_cycles(150);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
